// File: rtl/fsm_lane_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : fsm_lane_encoder_if
// Description : FIFO-side bundle for the lane encoder. It carries the
//               raw-data input FIFO status, strobe and pops, and the output
//               FIFO full flag, push, last, clears and lane-mux select.
//               master = encoder side, slave = FIFO/datapath side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fsm_lane_encoder_if #(
  parameter int NUM_LANES = 4,
  parameter int SEL_W     = $clog2(NUM_LANES)
);
  logic                 raw_data_in_fifo_empty;
  logic [NUM_LANES-1:0] raw_data_in_wstrb;
  logic                 raw_data_in_fifo_pop;
  logic                 raw_data_in_index_pop;
  logic                 raw_data_in_wstrb_pop;
  logic                 raw_data_out_fifo_full;
  logic                 raw_data_out_fifo_push;
  logic                 raw_data_out_last;
  logic                 raw_data_out_fifo_clr;
  logic                 raw_data_out_index_clr;
  logic [SEL_W-1:0]     raw_data_sel;

  modport master (
    input  raw_data_in_fifo_empty, raw_data_in_wstrb, raw_data_out_fifo_full,
    output raw_data_in_fifo_pop, raw_data_in_index_pop, raw_data_in_wstrb_pop,
    output raw_data_out_fifo_push, raw_data_out_last,
    output raw_data_out_fifo_clr, raw_data_out_index_clr, raw_data_sel
  );

  modport slave (
    output raw_data_in_fifo_empty, raw_data_in_wstrb, raw_data_out_fifo_full,
    input  raw_data_in_fifo_pop, raw_data_in_index_pop, raw_data_in_wstrb_pop,
    input  raw_data_out_fifo_push, raw_data_out_last,
    input  raw_data_out_fifo_clr, raw_data_out_index_clr, raw_data_sel
  );
endinterface
`default_nettype wire

// File: rtl/fsm_lane_encoder.sv
`default_nettype none
// ============================================================================
// Module      : fsm_lane_encoder
// Description : Pops one raw word (data/index/strobe) from the input FIFOs and
//               walks the lane mux across it, pushing one encoded lane per
//               cycle into the output FIFO. Lanes whose strobe bit is clear
//               can be skipped; an all-skipped word is dropped with a pulse.
// Ports       : clk, reset_n (async, active low), soft_clr (sync clear)
//               bus           - FIFO handshake bundle (master side)
//               word_dropped  - 1-cycle pulse for a popped all-zero word
//               busy          - high in every state except RD_READY
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_lane_encoder #(
  parameter int  NUM_LANES        = 4,
  parameter int  SKIP_EMPTY_LANES = 1,
  localparam int SEL_W            = $clog2(NUM_LANES)
) (
  input  wire                 clk,
  input  wire                 reset_n,
  input  wire                 soft_clr,
  fsm_lane_encoder_if.master  bus,
  output logic                word_dropped,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RD_READY = 2'd1,
    S_ENCODE   = 2'd2
  } state_t;

  localparam logic [SEL_W:0] c_LANE_LIMIT = (SEL_W+1)'(NUM_LANES);

  state_t               r_state, w_state_nxt;
  logic [SEL_W-1:0]     r_index, w_index_nxt;
  logic [NUM_LANES-1:0] r_mask,  w_mask_nxt;

  logic [NUM_LANES-1:0] w_eff_mask;
  logic [NUM_LANES-1:0] w_above;
  logic [SEL_W-1:0]     w_first_idx;
  logic [SEL_W-1:0]     w_next_idx;
  logic                 w_last;
  logic                 w_index_bad;

  // Lane scanning: lowest set bit of the incoming mask, and lowest set bit of
  // the latched mask strictly above the current index.
  always_comb begin
    w_eff_mask  = (SKIP_EMPTY_LANES != 0) ? bus.raw_data_in_wstrb : '1;
    w_first_idx = '0;
    w_next_idx  = '0;
    w_above     = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (w_eff_mask[i]) w_first_idx = SEL_W'(i);
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      w_above[i] = r_mask[i] && (i > int'(r_index));
    end
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (w_above[i]) w_next_idx = SEL_W'(i);
    end
    w_last      = ~|w_above;
    // Only reachable for non-power-of-two lane counts.
    w_index_bad = ({1'b0, r_index} >= c_LANE_LIMIT);
  end

  always_comb begin
    w_state_nxt                = r_state;
    w_index_nxt                = r_index;
    w_mask_nxt                 = r_mask;
    bus.raw_data_in_fifo_pop   = 1'b0;
    bus.raw_data_out_fifo_push = 1'b0;
    bus.raw_data_out_last      = 1'b0;
    bus.raw_data_out_fifo_clr  = 1'b0;
    bus.raw_data_out_index_clr = 1'b0;
    word_dropped               = 1'b0;

    case (r_state)
      S_INIT: begin
        bus.raw_data_out_fifo_clr  = 1'b1;
        bus.raw_data_out_index_clr = 1'b1;
        w_index_nxt                = '0;
        w_mask_nxt                 = '0;
        w_state_nxt                = S_RD_READY;
      end
      S_RD_READY: begin
        // Only empty gates the pop; full matters only while encoding.
        if (!bus.raw_data_in_fifo_empty) begin
          bus.raw_data_in_fifo_pop = 1'b1;
          w_mask_nxt               = w_eff_mask;
          w_index_nxt              = w_first_idx;
          if (w_eff_mask == '0) begin
            word_dropped = 1'b1;
          end else begin
            w_state_nxt = S_ENCODE;
          end
        end
      end
      S_ENCODE: begin
        if (w_index_bad) begin
          w_state_nxt = S_INIT;
        end else if (!bus.raw_data_out_fifo_full) begin
          bus.raw_data_out_fifo_push = 1'b1;
          bus.raw_data_out_last      = w_last;
          if (w_last) begin
            w_state_nxt = S_RD_READY;
            w_index_nxt = '0;
          end else begin
            w_index_nxt = w_next_idx;
          end
        end
      end
      default: w_state_nxt = S_INIT;
    endcase

    // Soft clear abandons any word in flight; INIT then flushes the outputs.
    if (soft_clr) begin
      w_state_nxt                = S_INIT;
      w_index_nxt                = r_index;
      w_mask_nxt                 = r_mask;
      bus.raw_data_in_fifo_pop   = 1'b0;
      bus.raw_data_out_fifo_push = 1'b0;
      bus.raw_data_out_last      = 1'b0;
      word_dropped               = 1'b0;
    end
  end

  assign bus.raw_data_in_index_pop = bus.raw_data_in_fifo_pop;
  assign bus.raw_data_in_wstrb_pop = bus.raw_data_in_fifo_pop;
  assign bus.raw_data_sel          = r_index;
  assign busy                      = (r_state != S_RD_READY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_INIT;
      r_index <= '0;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_index <= w_index_nxt;
      r_mask  <= w_mask_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fsm_lane_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fsm_lane_encoder
// Description : Bench for fsm_lane_encoder. Instance A (4 lanes, skipping) is
//               fed from a queue-backed input FIFO and checked by a scoreboard
//               built from the strobe rules; instance B (8 lanes, no skip)
//               covers full-width encoding and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_lane_encoder;

  typedef struct {
    bit drop;
    int sel;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a_n, rst_b_n, soft_a, soft_b;
  logic drop_a, busy_a, drop_b, busy_b;

  fsm_lane_encoder_if #(.NUM_LANES(4)) bus_a ();
  fsm_lane_encoder_if #(.NUM_LANES(8)) bus_b ();

  fsm_lane_encoder #(.NUM_LANES(4), .SKIP_EMPTY_LANES(1)) dut_a (
    .clk(clk), .reset_n(rst_a_n), .soft_clr(soft_a), .bus(bus_a),
    .word_dropped(drop_a), .busy(busy_a));

  fsm_lane_encoder #(.NUM_LANES(8), .SKIP_EMPTY_LANES(0)) dut_b (
    .clk(clk), .reset_n(rst_b_n), .soft_clr(soft_b), .bus(bus_b),
    .word_dropped(drop_b), .busy(busy_b));

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  logic [3:0] in_q[$];
  bit   sb_en     = 1'b1;
  bit   rand_full = 1'b0;
  logic pop_seen_a = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Packed view: {pop x3, push, last, drop, clr x2, busy, sel[7:0]}
  function automatic logic [31:0] mk(bit p, bit push, int sel, bit last, bit drop, bit clr, bit busy);
    return {15'd0, p, p, p, push, last, drop, clr, clr, busy, 8'(sel)};
  endfunction

  function automatic logic [31:0] obs_a();
    return {15'd0, bus_a.raw_data_in_fifo_pop, bus_a.raw_data_in_index_pop,
            bus_a.raw_data_in_wstrb_pop, bus_a.raw_data_out_fifo_push,
            bus_a.raw_data_out_last, drop_a, bus_a.raw_data_out_fifo_clr,
            bus_a.raw_data_out_index_clr, busy_a, 8'(bus_a.raw_data_sel)};
  endfunction

  function automatic logic [31:0] obs_b();
    return {15'd0, bus_b.raw_data_in_fifo_pop, bus_b.raw_data_in_index_pop,
            bus_b.raw_data_in_wstrb_pop, bus_b.raw_data_out_fifo_push,
            bus_b.raw_data_out_last, drop_b, bus_b.raw_data_out_fifo_clr,
            bus_b.raw_data_out_index_clr, busy_b, 8'(bus_b.raw_data_sel)};
  endfunction

  // Reference model: each set strobe bit yields one lane in ascending order,
  // the highest set bit is last; an all-zero strobe is a dropped word.
  task automatic enqueue_a(logic [3:0] w);
    in_q.push_back(w);
    if (sb_en) begin
      if (w == 4'd0) begin
        exp_q.push_back('{drop: 1'b1, sel: 0, last: 1'b0});
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (w[i]) exp_q.push_back('{drop: 1'b0, sel: i, last: ((w >> (i + 1)) == 4'd0)});
        end
      end
    end
  endtask

  task automatic cyc_a(bit full_v, bit soft_v, string name, bit p, bit push,
                       int sel, bit last, bit drop, bit clr, bit busy);
    logic [31:0] act;
    @(posedge clk);
    #1;
    bus_a.raw_data_out_fifo_full = full_v;
    soft_a = soft_v;
    @(negedge clk);
    act = obs_a();
    if (sel < 0) act[7:0] = 8'd0;
    chk(name, act, mk(p, push, (sel < 0) ? 0 : sel, last, drop, clr, busy));
  endtask

  task automatic cyc_b(bit empty_v, string name, bit p, bit push, int sel,
                       bit last, bit drop, bit clr, bit busy);
    @(posedge clk);
    #1;
    bus_b.raw_data_in_fifo_empty = empty_v;
    @(negedge clk);
    chk(name, obs_b(), mk(p, push, sel, last, drop, clr, busy));
  endtask

  // Queue-backed first-word-fall-through input FIFO for instance A.
  always @(posedge clk) begin
    #2;
    if (pop_seen_a && in_q.size() > 0) in_q.delete(0);
    bus_a.raw_data_in_fifo_empty = (in_q.size() == 0);
    bus_a.raw_data_in_wstrb      = (in_q.size() == 0) ? 4'd0 : in_q[0];
  end

  always @(posedge clk) begin
    if (rand_full) begin
      #1;
      bus_a.raw_data_out_fifo_full = ($urandom_range(0, 99) < 30);
    end
  end

  // Scoreboard monitor for instance A.
  always @(negedge clk) begin
    exp_t e;
    pop_seen_a = bus_a.raw_data_in_fifo_pop;
    if (sb_en && rst_a_n) begin
      if (bus_a.raw_data_in_fifo_pop) chk("pop_gate_empty", 32'(bus_a.raw_data_in_fifo_empty), 32'd0);
      if (bus_a.raw_data_out_fifo_push) begin
        chk("push_gate_full", 32'(bus_a.raw_data_out_fifo_full), 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_push: unexpected push sel=%0d at %0t", bus_a.raw_data_sel, $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_push", {23'd0, 8'(bus_a.raw_data_sel), bus_a.raw_data_out_last},
              {23'd0, e.drop ? 8'hFF : 8'(e.sel), e.last});
        end
      end
      if (drop_a) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_drop: unexpected word_dropped at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_drop", 32'(drop_a), 32'(e.drop));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    soft_a  = 1'b0;
    soft_b  = 1'b0;
    bus_a.raw_data_in_fifo_empty = 1'b1;
    bus_a.raw_data_in_wstrb      = 4'd0;
    bus_a.raw_data_out_fifo_full = 1'b0;
    bus_b.raw_data_in_fifo_empty = 1'b1;
    bus_b.raw_data_in_wstrb      = 8'd0;
    bus_b.raw_data_out_fifo_full = 1'b0;

    // Reset state, then exactly one INIT cycle, then idle in RD_READY.
    @(negedge clk);
    chk("reset_a", obs_a(), mk(0, 0, 0, 0, 0, 1, 1));
    chk("reset_b", obs_b(), mk(0, 0, 0, 0, 0, 1, 1));
    @(posedge clk);
    #1;
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    @(negedge clk);
    chk("init_a", obs_a(), mk(0, 0, 0, 0, 0, 1, 1));
    for (int i = 0; i < 20; i++) cyc_a(0, 0, "idle_a", 0, 0, 0, 0, 0, 0, 0);

    // Full word, no stalls: pop then sel 0..3, last on 3.
    enqueue_a(4'b1111);
    cyc_a(0, 0, "w1111_pop", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc_a(0, 0, "w1111_push", 0, 1, i, (i == 3), 0, 0, 1);
    cyc_a(0, 0, "w1111_done", 0, 0, 0, 0, 0, 0, 0);

    // Sparse strobe, then an all-zero strobe.
    enqueue_a(4'b1010);
    cyc_a(0, 0, "w1010_pop", 1, 0, 0, 0, 0, 0, 0);
    cyc_a(0, 0, "w1010_sel1", 0, 1, 1, 0, 0, 0, 1);
    cyc_a(0, 0, "w1010_sel3", 0, 1, 3, 1, 0, 0, 1);
    enqueue_a(4'b0000);
    cyc_a(0, 0, "w0000_drop", 1, 0, 0, 0, 1, 0, 0);
    cyc_a(0, 0, "w0000_idle", 0, 0, 0, 0, 0, 0, 0);

    // Output full for 5 cycles while sel = 2.
    enqueue_a(4'b1111);
    cyc_a(0, 0, "stall_pop", 1, 0, 0, 0, 0, 0, 0);
    cyc_a(0, 0, "stall_sel0", 0, 1, 0, 0, 0, 0, 1);
    cyc_a(0, 0, "stall_sel1", 0, 1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc_a(1, 0, "stall_hold", 0, 0, 2, 0, 0, 0, 1);
    cyc_a(0, 0, "stall_sel2", 0, 1, 2, 0, 0, 0, 1);
    cyc_a(0, 0, "stall_sel3", 0, 1, 3, 1, 0, 0, 1);
    cyc_a(0, 0, "stall_done", 0, 0, 0, 0, 0, 0, 0);

    // Soft clear on the second push abandons the word.
    sb_en = 1'b0;
    exp_q.delete();
    enqueue_a(4'b1111);
    cyc_a(0, 0, "sclr_pop", 1, 0, 0, 0, 0, 0, 0);
    cyc_a(0, 0, "sclr_sel0", 0, 1, 0, 0, 0, 0, 1);
    cyc_a(0, 1, "sclr_cycle", 0, 0, 1, 0, 0, 0, 1);
    cyc_a(0, 0, "sclr_init", 0, 0, -1, 0, 0, 1, 1);
    cyc_a(0, 0, "sclr_ready", 0, 0, 0, 0, 0, 0, 0);
    sb_en = 1'b1;
    enqueue_a(4'b1111);
    cyc_a(0, 0, "restart_pop", 1, 0, 0, 0, 0, 0, 0);
    cyc_a(0, 0, "restart_sel0", 0, 1, 0, 0, 0, 0, 1);
    for (int i = 1; i < 4; i++) cyc_a(0, 0, "restart_push", 0, 1, i, (i == 3), 0, 0, 1);

    // Randomised traffic with random back-pressure.
    rand_full = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 99) < 35) enqueue_a(4'($urandom_range(0, 15)));
    end
    rand_full = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    bus_a.raw_data_out_fifo_full = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (in_q.size() == 0 && exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_expected", 32'(exp_q.size()), 32'd0);
    chk("drain_input", 32'(in_q.size()), 32'd0);
    @(negedge clk);
    chk("final_idle_a", obs_a(), mk(0, 0, 0, 0, 0, 0, 0));

    // Instance B: 8 lanes, strobe ignored, zero strobe still fully encoded.
    cyc_b(0, "b_pop", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc_b(1, "b_push", 0, 1, i, (i == 7), 0, 0, 1);
    cyc_b(1, "b_done", 0, 0, 0, 0, 0, 0, 0);

    // Instance B: reset dropped mid-word takes effect without a clock edge.
    cyc_b(0, "b2_pop", 1, 0, 0, 0, 0, 0, 0);
    cyc_b(1, "b2_sel0", 0, 1, 0, 0, 0, 0, 1);
    cyc_b(1, "b2_sel1", 0, 1, 1, 0, 0, 0, 1);
    @(posedge clk);
    #3;
    rst_b_n = 1'b0;
    #1;
    chk("b_async_reset", obs_b(), mk(0, 0, 0, 0, 0, 1, 1));
    @(posedge clk);
    #1;
    rst_b_n = 1'b1;
    @(negedge clk);
    chk("b_init_after_reset", obs_b(), mk(0, 0, 0, 0, 0, 1, 1));
    cyc_b(1, "b_ready_after_reset", 0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fsm_lane_encoder.md
Name: fsm_lane_encoder

Overview:
- Parametrised successor of the single-word, 4-lane encode sequencer.
- Pops one raw word, plus its index and write strobe, from the raw-data input FIFO.
- Steps the raw-data lane mux across the word one lane per cycle and pushes each encoded lane into the raw-data output FIFO, stalling on full.
- New over the previous generation: configurable lane count, optional strobe-driven lane skipping, explicit push/last signalling, synchronous soft clear.

Parameters:
- NUM_LANES, 4, lanes per raw word; must be ≥2.
- SKIP_EMPTY_LANES, 1, 1 = lanes whose strobe bit is 0 are skipped; 0 = every lane is encoded regardless of strobe.
- SEL_W, $clog2(NUM_LANES), lane-select width; derived, not overridden.

Ports:
- clk  input  1  single block clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- soft_clr  input  1  synchronous clear; returns the FSM to INIT.
- raw_data_in_fifo_empty  input  1  input FIFO empty (first-word-fall-through).
- raw_data_in_wstrb  input  NUM_LANES  strobe of the head entry; valid while not empty.
- raw_data_in_fifo_pop  output  1  pop data FIFO.
- raw_data_in_index_pop  output  1  pop index FIFO.
- raw_data_in_wstrb_pop  output  1  pop strobe FIFO.
- raw_data_out_fifo_full  input  1  output FIFO full.
- raw_data_out_fifo_push  output  1  push the currently selected encoded lane.
- raw_data_out_last  output  1  qualifies a push as the last lane of the word.
- raw_data_out_fifo_clr  output  1  clear output FIFO.
- raw_data_out_index_clr  output  1  clear output index FIFO.
- raw_data_sel  output  SEL_W  lane-mux select.
- word_dropped  output  1  one-cycle pulse when a popped word has an all-zero strobe (skip mode only).
- busy  output  1  high in every state except RD_READY.

Behaviour:
- States: INIT, RD_READY, ENCODE.
- Reset (reset_n low, asynchronous): state = INIT; index and mask registers = 0. Since the FSM then sits in INIT, the clr outputs are high and every other output is 0; raw_data_sel = 0.
- All outputs are decoded combinationally from registered state, index and mask. Pops and pushes depend on empty/full in the same cycle.
- raw_data_sel always equals the index register. It holds its value outside ENCODE.
- INIT (exactly 1 cycle):
  - Assert raw_data_out_fifo_clr and raw_data_out_index_clr.
  - index = 0, mask = 0.
  - Next state: RD_READY.
- RD_READY:
  - If empty: no pop; stay in RD_READY.
  - If not empty:
    - Assert all three pop signals for exactly that cycle.
    - Effective mask = raw_data_in_wstrb when SKIP_EMPTY_LANES = 1, otherwise all ones. Latch it.
    - index = lowest set bit of the effective mask.
    - Effective mask zero: pulse word_dropped; stay in RD_READY; the word is consumed with no push.
    - Otherwise: go to ENCODE.
  - Pops never occur while empty.
- ENCODE:
  - Full: no push; hold state and index (stall of any length).
  - Not full:
    - Assert raw_data_out_fifo_push.
    - raw_data_out_last = 1 if no set mask bit lies above index.
    - If last: go to RD_READY; index = 0.
    - Otherwise: index = next set bit above index; stay in ENCODE.
- Throughput: a word with k encoded lanes and no stalls takes k+1 cycles (1 pop cycle + k push cycles). The first push comes 1 cycle after the pop.
- Index never wraps past NUM_LANES-1. An index ≥ NUM_LANES (non-power-of-2 NUM_LANES) or any illegal state goes to INIT.
- soft_clr:
  - Highest priority over all state logic; next state = INIT.
  - In the same cycle: no pop, no push, word_dropped = 0.
  - A partially encoded word is abandoned. Its remaining lanes are lost and the output FIFOs are cleared by INIT.
- Reset asserted mid-word behaves as soft_clr but asynchronously.
- full and empty asserted together in RD_READY: pop still proceeds (empty alone gates the pop); full only stalls in ENCODE.

Test Plan:
- Reset release, input empty: 1 cycle with both clr = 1, then RD_READY; no pops for 20 cycles; busy = 0.
- NUM_LANES=4, SKIP=1, wstrb=4'b1111, never full: pop at t; pushes at t+1..t+4 with sel 0,1,2,3; last only at t+4; back in RD_READY at t+5.
- wstrb=4'b1010: pushes with sel 1 then 3; last on sel 3; 3 cycles total. With wstrb=4'b0000: one pop, word_dropped pulse, no push, stays in RD_READY.
- Full asserted for 5 cycles while in ENCODE with sel=2: no push and sel held at 2 for 5 cycles; push with sel 2 on the first not-full cycle.
- soft_clr at the second push of a 4-lane word: next cycle INIT (clr = 1), no push in the soft_clr cycle; the following word restarts at sel 0.
- NUM_LANES=8, SKIP=0, wstrb=0: 8 pushes with sel 0..7, last on 7, no word_dropped; repeat with reset_n dropped mid-word: outputs go to reset values immediately, without waiting for a clock edge.
